// File: rtl/mbist_controller_if.sv
// mbist_controller_if: groups the BIST-side memory bus and the test control/status lines.
// Latency: none, this is wiring only. Backpressure: none, the memory accepts one op per cycle.
// Ports: master = controller (drives NbarT/addr/wdata/we/re/done/fail/fail_addr, samples start/rdata);
//        slave = memory/test host (drives start/rdata, samples the rest).
interface mbist_controller_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 10
);
  logic                  start;
  logic                  NbarT;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;

  modport master (
    input  start, rdata,
    output NbarT, addr, wdata, we, re, done, fail, fail_addr
  );

  modport slave (
    output start, rdata,
    input  NbarT, addr, wdata, we, re, done, fail, fail_addr
  );
endinterface

// File: rtl/mbist_controller.sv
// mbist_controller: March C- sequencer for a single-port synchronous memory (10*2^ADDR_WIDTH ops).
// Latency: first op registered on the start edge; each read compared 2 edges after it is issued.
// Backpressure: none; one op per cycle, start ignored while running.
// Ports: clk, rst (async active-high), bus (mbist_controller_if.master: start, rdata in;
//        NbarT, addr, wdata, we, re, done, fail, fail_addr out; all outputs registered).
// Option: define MBIST_STOP_ON_FAIL_EN to end the test at the first mismatching compare.
module mbist_controller #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  mbist_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] BG_ONE   = '1;
  localparam logic [DATA_WIDTH-1:0] BG_ZERO  = '0;

  state_t                state_q, state_n;
  logic [2:0]            elem_q, elem_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                  we_q, we_n;
  logic                  re_q, re_n;
  logic                  nbart_q, nbart_n;
  logic                  done_q, done_n;
  logic                  fail_q, fail_n;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_n;
  // compare stage: holds the read issued on the previous cycle
  logic                  cmp_vld_q, cmp_vld_n;
  logic                  cmp_last_q, cmp_last_n;
  logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_n;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_n;

  logic elem_up;
  logic elem_last_addr;
  logic op_active;
  logic mismatch;

  // Background written by each element: E1 and E3 write ones, E0/E2/E4 write zeros.
  function automatic logic [DATA_WIDTH-1:0] wr_bg(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? BG_ONE : BG_ZERO;
  endfunction

  // Background expected by each element's read: E2 and E4 read ones, the rest zeros.
  function automatic logic [DATA_WIDTH-1:0] rd_bg(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? BG_ONE : BG_ZERO;
  endfunction

  always_comb begin
    elem_up        = !(elem_q == 3'd3 || elem_q == 3'd4);
    elem_last_addr = elem_up ? (addr_q == ADDR_MAX) : (addr_q == '0);
  end

  // The registered strobes double as the op phase; both low in RUN means draining compares.
  assign op_active = we_q | re_q;
  assign mismatch  = cmp_vld_q && (bus.rdata != cmp_exp_q);

  always_comb begin
    state_n     = state_q;
    elem_n      = elem_q;
    addr_n      = '0;
    wdata_n     = '0;
    we_n        = 1'b0;
    re_n        = 1'b0;
    nbart_n     = 1'b0;
    done_n      = done_q;
    fail_n      = fail_q;
    fail_addr_n = fail_addr_q;
    cmp_vld_n   = 1'b0;
    cmp_last_n  = 1'b0;
    cmp_exp_n   = '0;
    cmp_addr_n  = '0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // first op of E0 (w0 at address 0) goes out on this same edge
          state_n     = RUN;
          nbart_n     = 1'b1;
          elem_n      = 3'd0;
          we_n        = 1'b1;
          done_n      = 1'b0;
          fail_n      = 1'b0;
          fail_addr_n = '0;
        end
      end

      RUN: begin
        nbart_n    = 1'b1;
        cmp_vld_n  = re_q;
        cmp_last_n = re_q && (elem_q == 3'd5) && (addr_q == ADDR_MAX);
        cmp_exp_n  = re_q ? rd_bg(elem_q) : BG_ZERO;
        cmp_addr_n = addr_q;

        if (re_q && elem_q != 3'd5) begin
          // read-then-write pair on the same address
          we_n    = 1'b1;
          addr_n  = addr_q;
          wdata_n = wr_bg(elem_q);
        end else if (op_active && !elem_last_addr) begin
          addr_n = elem_up ? addr_q + 1'b1 : addr_q - 1'b1;
          if (elem_q == 3'd0) begin
            we_n = 1'b1;
          end else begin
            re_n = 1'b1;
          end
        end else if (op_active && elem_q != 3'd5) begin
          // element boundary: every element after E0 opens with a read
          elem_n = elem_q + 3'd1;
          addr_n = (elem_q == 3'd2 || elem_q == 3'd3) ? ADDR_MAX : '0;
          re_n   = 1'b1;
        end

        if (mismatch && !fail_q) begin
          fail_n      = 1'b1;
          fail_addr_n = cmp_addr_q;
        end

`ifdef MBIST_STOP_ON_FAIL_EN
        if (mismatch || (cmp_vld_q && cmp_last_q)) begin
`else
        if (cmp_vld_q && cmp_last_q) begin
`endif
          state_n    = DONE;
          done_n     = 1'b1;
          nbart_n    = 1'b0;
          we_n       = 1'b0;
          re_n       = 1'b0;
          addr_n     = '0;
          wdata_n    = '0;
          cmp_vld_n  = 1'b0;
          cmp_last_n = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      nbart_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_last_q  <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_n;
      elem_q      <= elem_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      we_q        <= we_n;
      re_q        <= re_n;
      nbart_q     <= nbart_n;
      done_q      <= done_n;
      fail_q      <= fail_n;
      fail_addr_q <= fail_addr_n;
      cmp_vld_q   <= cmp_vld_n;
      cmp_last_q  <= cmp_last_n;
      cmp_exp_q   <= cmp_exp_n;
      cmp_addr_q  <= cmp_addr_n;
    end
  end

  assign bus.NbarT     = nbart_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.we        = we_q;
  assign bus.re        = re_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;

endmodule

// File: tb/tb_mbist_controller.sv
// tb_mbist_controller: scoreboard bench for mbist_controller against a 16x10 memory model.
// Latency: expected ops and completion events are stamped with the edge they must appear on.
// Backpressure: none; the monitor consumes one DUT op per cycle.
module tb_mbist_controller;

  typedef struct {
    int         edge_n;
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [9:0] wdata;
  } op_t;

  typedef struct {
    int         edge_n;
    logic       fail;
    logic [3:0] fail_addr;
    int         nb_cycles;
  } evt_t;

  logic clk;
  logic rst;
  bit   fault;
  int   edge_cnt;
  int   checks;
  int   errors;
  int   nb_cnt;
  logic done_prev;
  logic [9:0] mem [16];

  op_t  op_q[$];
  evt_t evt_q[$];

  // March C- element table
  bit e_rd   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  bit e_wr   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit e_down [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit e_wone [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  mbist_controller_if #(.ADDR_WIDTH(4), .DATA_WIDTH(10)) bus ();

  mbist_controller #(.ADDR_WIDTH(4), .DATA_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  // Memory model: 1-cycle read latency; optional stuck-at-1 on bit 3 of address 5.
  always @(posedge clk) begin
    if (bus.we) mem[bus.addr] <= bus.wdata;
    if (bus.re) bus.rdata <= mem[bus.addr] | ((fault && bus.addr == 4'd5) ? 10'h008 : 10'h000);
  end

  // Monitor: pops the scoreboard whenever the DUT issues an op or raises done.
  always @(negedge clk) begin
    op_t  eo;
    evt_t ev;
    if (rst) begin
      nb_cnt    = 0;
      done_prev = 1'b0;
    end else begin
      if (bus.NbarT) nb_cnt++;
      if (bus.we || bus.re) begin
        checks++;
        if (op_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_op edge=%0d we=%0b re=%0b addr=%0d", edge_cnt, bus.we, bus.re, bus.addr);
        end else begin
          eo = op_q.pop_front();
          if (eo.edge_n != edge_cnt || eo.we !== bus.we || eo.re !== bus.re ||
              eo.addr !== bus.addr || eo.wdata !== bus.wdata) begin
            errors++;
            $display("FAIL op got edge=%0d we=%0b re=%0b addr=%0d wdata=%h expected edge=%0d we=%0b re=%0b addr=%0d wdata=%h",
                     edge_cnt, bus.we, bus.re, bus.addr, bus.wdata,
                     eo.edge_n, eo.we, eo.re, eo.addr, eo.wdata);
          end
        end
      end
      if (bus.done && !done_prev) begin
        checks++;
        if (evt_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done edge=%0d", edge_cnt);
        end else begin
          ev = evt_q.pop_front();
          if (ev.edge_n != edge_cnt || ev.fail !== bus.fail || ev.fail_addr !== bus.fail_addr ||
              bus.NbarT !== 1'b0 || ev.nb_cycles != nb_cnt || op_q.size() != 0) begin
            errors++;
            $display("FAIL done_evt got edge=%0d fail=%0b fail_addr=%0d NbarT=%0b nb_cycles=%0d ops_left=%0d expected edge=%0d fail=%0b fail_addr=%0d NbarT=0 nb_cycles=%0d ops_left=0",
                     edge_cnt, bus.fail, bus.fail_addr, bus.NbarT, nb_cnt, op_q.size(),
                     ev.edge_n, ev.fail, ev.fail_addr, ev.nb_cycles);
          end
        end
        nb_cnt = 0;
      end
      done_prev = bus.done;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_NbarT"}, int'(bus.NbarT), 0);
    chk({tag, "_we"}, int'(bus.we), 0);
    chk({tag, "_re"}, int'(bus.re), 0);
    chk({tag, "_addr"}, int'(bus.addr), 0);
    chk({tag, "_wdata"}, int'(bus.wdata), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_fail"}, int'(bus.fail), 0);
    chk({tag, "_fail_addr"}, int'(bus.fail_addr), 0);
  endtask

  // Queue the expected March C- op stream and completion event for a run whose
  // start is sampled at edge base+1 (that edge is "edge 1" of the run).
  task automatic push_run(input int base, input bit faulty);
    op_t  o;
    evt_t ev;
    int   idx;
    int   last_idx;
    bit   stop_early;
    logic [3:0] a;
`ifdef MBIST_STOP_ON_FAIL_EN
    stop_early = faulty;
`else
    stop_early = 1'b0;
`endif
    // stop-on-fail: E1 r0 of addr 5 is op 26; its w1 (op 27) is already out before the compare
    last_idx = stop_early ? 27 : 159;
    idx = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 16; k++) begin
        a = e_down[e] ? 4'(15 - k) : 4'(k);
        if (e_rd[e]) begin
          o = '{edge_n: base + 1 + idx, we: 1'b0, re: 1'b1, addr: a, wdata: 10'h000};
          if (idx <= last_idx) op_q.push_back(o);
          idx++;
        end
        if (e_wr[e]) begin
          o = '{edge_n: base + 1 + idx, we: 1'b1, re: 1'b0, addr: a,
                wdata: e_wone[e] ? 10'h3FF : 10'h000};
          if (idx <= last_idx) op_q.push_back(o);
          idx++;
        end
      end
    end
    ev.edge_n    = base + (stop_early ? 29 : 162);
    ev.fail      = faulty;
    ev.fail_addr = faulty ? 4'd5 : 4'd0;
    ev.nb_cycles = stop_early ? 28 : 161;
    evt_q.push_back(ev);
  endtask

  task automatic launch(input bit faulty, output int base);
    @(negedge clk);
    fault     = faulty;
    base      = edge_cnt;
    push_run(base, faulty);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got done=0 expected done=1 within 400 cycles");
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    checks    = 0;
    errors    = 0;
    edge_cnt  = 0;
    nb_cnt    = 0;
    done_prev = 1'b0;
    fault     = 1'b0;
    bus.start = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("reset");

    // Run A: fault-free, with a stray start pulse sampled at edge 40
    launch(1'b0, base);
    while (edge_cnt < base + 39) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Run B: restart from DONE with the stuck-at fault
    launch(1'b1, base);
    chk("restartB_done_cleared", int'(bus.done), 0);
    chk("restartB_NbarT", int'(bus.NbarT), 1);
    wait_done();
    chk("runB_fail_held", int'(bus.fail), 1);
    chk("runB_fail_addr_held", int'(bus.fail_addr), 5);

    // Run C: fault removed; restart must clear the sticky fail
    launch(1'b0, base);
    chk("restartC_done_cleared", int'(bus.done), 0);
    chk("restartC_fail_cleared", int'(bus.fail), 0);
    chk("restartC_fail_addr_cleared", int'(bus.fail_addr), 0);
    wait_done();

    // Run D: asynchronous reset between edges 50 and 51 aborts the run
    launch(1'b0, base);
    while (edge_cnt < base + 50) @(negedge clk);
    chk("runD_NbarT_before_rst", int'(bus.NbarT), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("async_rst");
    op_q.delete();
    evt_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Run E: clean run after the abort
    launch(1'b0, base);
    wait_done();
    chk("runE_fail", int'(bus.fail), 0);

    repeat (3) @(negedge clk);
    chk("final_ops_left", op_q.size(), 0);
    chk("final_evts_left", evt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
